sdram_slot_arbiter: RTL

Parametrised SDRAM arbiter between the Vector-06C video/CPU side (VU) and the ZPU soft core. VU accesses pass straight through to the SDRAM controller. Free `access_slot` cycles are shared between auto-refresh and ZPU traffic at a programmable ratio. ZPU 8/16/32-bit reads and writes are executed as one or two 16-bit SDRAM accesses, with byte enables, big-endian lane ordering and a busy/done handshake.

---
 rtl/sdram_slot_arbiter_if.sv | 46 ++++
 rtl/sdram_slot_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sdram_slot_arbiter_if.sv
// Bus bundle between the VU/ZPU requesters, the slot arbiter and the SDRAM controller.
// The arbiter takes the slave view; whatever drives requests and models the controller takes the master view.
interface sdram_slot_arbiter_if #(
  parameter int VU_ABUS_WIDTH  = 18,
  parameter int ZPU_ABUS_WIDTH = 22
);
  logic [VU_ABUS_WIDTH-1:0]  vu_adrs;
  logic [7:0]                vu_data;
  logic                      vu_read;
  logic                      vu_write;
  logic [7:0]                vu_q;
  logic                      access_slot;
  logic [ZPU_ABUS_WIDTH-1:0] zpu_adrs;
  logic [31:0]               zpu_data;
  logic                      zpu_read;
  logic                      zpu_write;
  logic                      zpu_halfword;
  logic                      zpu_byte;
  logic                      zpu_busy;
  logic                      zpu_done;
  logic [31:0]               zpu_q;
  logic [21:0]               sdram_addr;
  logic [15:0]               data_to_sdram;
  logic                      sdram_read;
  logic                      sdram_write;
  logic                      sdram_refresh;
  logic                      sdram_lb;
  logic                      sdram_ub;
  logic [15:0]               sdram_dq;

  modport slave (
    input  vu_adrs, vu_data, vu_read, vu_write, access_slot,
    input  zpu_adrs, zpu_data, zpu_read, zpu_write, zpu_halfword, zpu_byte,
    input  sdram_dq,
    output vu_q, zpu_busy, zpu_done, zpu_q,
    output sdram_addr, data_to_sdram, sdram_read, sdram_write, sdram_refresh, sdram_lb, sdram_ub
  );

  modport master (
    output vu_adrs, vu_data, vu_read, vu_write, access_slot,
    output zpu_adrs, zpu_data, zpu_read, zpu_write, zpu_halfword, zpu_byte,
    output sdram_dq,
    input  vu_q, zpu_busy, zpu_done, zpu_q,
    input  sdram_addr, data_to_sdram, sdram_read, sdram_write, sdram_refresh, sdram_lb, sdram_ub
  );
endinterface

// File: rtl/sdram_slot_arbiter.sv
// SDRAM arbiter: VU passes straight through; free access slots alternate between
// auto-refresh and ZPU 8/16/32-bit accesses split into 16-bit big-endian halves.
module sdram_slot_arbiter #(
  parameter int VU_ABUS_WIDTH  = 18,
  parameter int ZPU_ABUS_WIDTH = 22,
  parameter int REFRESH_EVERY  = 2,
  parameter int RD_LAT         = 2
) (
  input  logic                clk,
  input  logic                reset,
  sdram_slot_arbiter_if.slave bus
);
  localparam int SW = $clog2(REFRESH_EVERY);
  localparam logic [SW-1:0] SCNT_LAST = SW'(REFRESH_EVERY - 1);

  typedef enum logic [1:0] {IDLE, ACC_HI, ACC_LO, WAIT_RD} state_t;
  typedef enum logic [1:0] {SZ_32, SZ_16, SZ_8} size_t;

  state_t                    state;
  logic [SW-1:0]             scnt;
  logic                      busy_r;
  logic                      done_r;
  logic [31:0]               q_r;
  logic [ZPU_ABUS_WIDTH-1:0] adrs_r;
  logic [31:0]               data_r;
  size_t                     size_r;
  logic                      rd_r;
  logic [15:0]               hi_r;
  logic [RD_LAT-1:0]         tag_vld_p;
  logic [RD_LAT-1:0]         tag_half_p;

  logic [VU_ABUS_WIDTH-1:0]  vu_adrs;
  logic                      vu_act, slot_ok, refresh_slot, zpu_slot, zpu_issue;
  logic                      accept, tag_vld, tag_half, tag_last;
  logic [21:0]               zpu_base, zpu_word;
  logic [15:0]               zpu_wdata;
  logic                      zpu_ub, zpu_lb;
  logic [7:0]                rd_byte;
  logic [31:0]               rd_result;

  assign vu_adrs      = bus.vu_adrs;
  assign vu_act       = bus.vu_read | bus.vu_write;
  // A slot that collides with VU traffic is ignored entirely, not even counted.
  assign slot_ok      = bus.access_slot & ~vu_act & ~reset;
  assign refresh_slot = slot_ok & (scnt == '0);
  assign zpu_slot     = slot_ok & (scnt != '0);
  assign zpu_issue    = zpu_slot & ((state == ACC_HI) || (state == ACC_LO));
  assign accept       = (state == IDLE) & (bus.zpu_read ^ bus.zpu_write);

  assign tag_vld  = tag_vld_p[RD_LAT-1];
  assign tag_half = tag_half_p[RD_LAT-1];
  assign tag_last = tag_vld & (~tag_half | (size_r != SZ_32));

  // 32-bit accesses ignore adrs[1:0]: HI is the even word, LO the odd one.
  assign zpu_base = 22'(adrs_r >> 1);
  assign zpu_word = (size_r == SZ_32) ? {zpu_base[21:1], state == ACC_LO} : zpu_base;

  always_comb begin
    zpu_wdata = data_r[15:0];
    zpu_ub    = 1'b1;
    zpu_lb    = 1'b1;
    case (size_r)
      SZ_32:   zpu_wdata = (state == ACC_LO) ? data_r[15:0] : data_r[31:16];
      SZ_8: begin
        zpu_wdata = {data_r[7:0], data_r[7:0]};
        zpu_ub    = ~adrs_r[0];
        zpu_lb    = adrs_r[0];
      end
      default: zpu_wdata = data_r[15:0];
    endcase
  end

  always_comb begin
    rd_byte   = adrs_r[0] ? bus.sdram_dq[7:0] : bus.sdram_dq[15:8];
    rd_result = {16'h0000, bus.sdram_dq};
    case (size_r)
      SZ_32:   rd_result = {hi_r, bus.sdram_dq};
      SZ_8:    rd_result = {24'h000000, rd_byte};
      default: rd_result = {16'h0000, bus.sdram_dq};
    endcase
  end

  always_comb begin
    if (vu_act) begin
      bus.sdram_addr    = 22'(vu_adrs >> 1);
      bus.data_to_sdram = {bus.vu_data, bus.vu_data};
      bus.sdram_read    = bus.vu_read;
      bus.sdram_write   = bus.vu_write;
      bus.sdram_refresh = 1'b0;
      bus.sdram_ub      = ~vu_adrs[0];
      bus.sdram_lb      = vu_adrs[0];
    end else begin
      bus.sdram_addr    = zpu_word;
      bus.data_to_sdram = zpu_wdata;
      bus.sdram_read    = zpu_issue & rd_r;
      bus.sdram_write   = zpu_issue & ~rd_r;
      bus.sdram_refresh = refresh_slot;
      bus.sdram_ub      = zpu_issue & zpu_ub;
      bus.sdram_lb      = zpu_issue & zpu_lb;
    end
  end

  assign bus.vu_q     = vu_adrs[0] ? bus.sdram_dq[7:0] : bus.sdram_dq[15:8];
  assign bus.zpu_busy = busy_r;
  assign bus.zpu_done = done_r;
  assign bus.zpu_q    = q_r;

  // Request latch
  always_ff @(posedge clk) begin
    if (accept) begin
      adrs_r <= bus.zpu_adrs;
      data_r <= bus.zpu_data;
      rd_r   <= bus.zpu_read;
      size_r <= bus.zpu_halfword ? SZ_16 : (bus.zpu_byte ? SZ_8 : SZ_32);
    end
  end

  // Read tag pipeline: p0 is loaded in the issuing slot, p[RD_LAT-1] lines up with valid dq
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld_p <= '0;
    end else begin
      tag_vld_p[0] <= zpu_issue & rd_r;
      for (int i = 1; i < RD_LAT; i++) tag_vld_p[i] <= tag_vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_half_p[0] <= (state == ACC_HI);
    for (int i = 1; i < RD_LAT; i++) tag_half_p[i] <= tag_half_p[i-1];
    if (tag_vld & tag_half) hi_r <= bus.sdram_dq;
  end

  // Slot counter and transaction FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      scnt   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      q_r    <= '0;
    end else begin
      done_r <= 1'b0;
      if (slot_ok) scnt <= (scnt == SCNT_LAST) ? '0 : scnt + 1'b1;
      case (state)
        IDLE: if (accept) begin
          state  <= ACC_HI;
          busy_r <= 1'b1;
        end
        ACC_HI: if (zpu_slot) begin
          if (size_r == SZ_32) state <= ACC_LO;
          else if (rd_r)       state <= WAIT_RD;
          else begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        ACC_LO: if (zpu_slot) begin
          if (rd_r) state <= WAIT_RD;
          else begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        WAIT_RD: if (tag_last) begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          q_r    <= rd_result;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
